// File: rtl/guvm_icache_responder.sv
// guvm_icache_responder: FIFO-fed instruction fetch responder for the LEON icache output port.
// Optional feature: define GUVM_ICRESP_EXC_INJECT_EN to add exc_inject_i, stored per entry and
// presented on ic_exception_o during that entry's delivery cycle.
module guvm_icache_responder #(
  parameter int          DEPTH    = 8,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_INST = 32'h01000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_valid_i,
  input  logic [31:0]                inst_i,
`ifdef GUVM_ICRESP_EXC_INJECT_EN
  input  logic                       exc_inject_i,
`endif
  output logic                       inst_ready_o,
  input  logic                       fetch_req_i,
  input  logic                       flush_i,
  output logic [31:0]                ic_data_o,
  output logic                       ic_hold_o,
  output logic                       ic_mds_o,
  output logic                       ic_exception_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
`ifdef GUVM_ICRESP_EXC_INJECT_EN
  localparam int W = 33;
  logic [W-1:0] wr_entry;
  assign wr_entry = {exc_inject_i, inst_i};
`else
  localparam int W = 32;
  logic [W-1:0] wr_entry;
  assign wr_entry = inst_i;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, STALL, DELIVER} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [W-1:0]  dlv_q;
  logic          push, pop, non_empty;
  assign non_empty    = count_q != '0;
  assign inst_ready_o = rst && (count_q < CW'(DEPTH));
  assign push         = inst_valid_i && inst_ready_o && !flush_i;
  assign pop          = state_d == DELIVER;
  assign count_d      = count_q + CW'(push) - CW'(pop);
  assign ic_data_o    = dlv_q[31:0];
  assign ic_hold_o    = state_q != DELIVER;
  assign ic_mds_o     = state_q != DELIVER;
  assign fifo_count_o = count_q;
`ifdef GUVM_ICRESP_EXC_INJECT_EN
  assign ic_exception_o = (state_q == DELIVER) && dlv_q[32];
`else
  assign ic_exception_o = 1'b0;
`endif
  // Fetch sequencing: latency countdown, stall on empty FIFO, single-cycle delivery.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        state_d = fetch_req_i ? WAIT : IDLE;
        lat_d   = LW'(LATENCY - 1);
      end
      WAIT: begin
        state_d = lat_q != '0 ? WAIT : (non_empty ? DELIVER : STALL);
        lat_d   = lat_q != '0 ? lat_q - 1'b1 : lat_q;
      end
      STALL: state_d = non_empty ? DELIVER : STALL;
      default: begin
        state_d = fetch_req_i ? WAIT : IDLE;
        lat_d   = LW'(LATENCY - 1);
      end
    endcase
  end
  // State, pointers and the delivered word; the head is captured and popped on entry to DELIVER.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dlv_q    <= W'(NOP_INST);
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dlv_q    <= mem_q[rd_ptr_q];
      end
    end
  end
  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

// File: tb/tb_guvm_icache_responder.sv
// tb_guvm_icache_responder: scoreboard bench for guvm_icache_responder (DEPTH=8, LATENCY=1).
module tb_guvm_icache_responder;
  localparam logic [31:0] NOP = 32'h01000000;
  logic        clk = 0, rst = 0, inst_valid = 0, fetch_req = 0, flush = 0, exc_inject = 0, mon_en = 0;
  logic [31:0] inst = 0;
  logic        inst_ready_o, ic_hold_o, ic_mds_o, ic_exception_o;
  logic [31:0] ic_data_o;
  logic [3:0]  fifo_count_o;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  guvm_icache_responder dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .inst_i(inst),
`ifdef GUVM_ICRESP_EXC_INJECT_EN
    .exc_inject_i(exc_inject),
`endif
    .inst_ready_o(inst_ready_o), .fetch_req_i(fetch_req), .flush_i(flush),
    .ic_data_o(ic_data_o), .ic_hold_o(ic_hold_o), .ic_mds_o(ic_mds_o),
    .ic_exception_o(ic_exception_o), .fifo_count_o(fifo_count_o)
  );

  // Scoreboard: every delivery cycle must match the oldest accepted word.
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (ic_mds_o !== ic_hold_o) begin
      errors++; $display("FAIL mds_vs_hold: mds=%b hold=%b", ic_mds_o, ic_hold_o);
    end
    if (ic_hold_o === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_delivery: data=%h, none expected", ic_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (ic_data_o !== mon_e[31:0] || ic_exception_o !== mon_e[32]) begin
          errors++;
          $display("FAIL delivery: data=%h exc=%b, expected data=%h exc=%b",
                   ic_data_o, ic_exception_o, mon_e[31:0], mon_e[32]);
        end
      end
    end else begin
      checks++;
      if (ic_exception_o !== 1'b0) begin
        errors++; $display("FAIL exc_outside_delivery: exc=%b expected 0", ic_exception_o);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f,
                      input logic e = 1'b0);
    @(negedge clk);
    inst_valid = v; inst = d; fetch_req = r; flush = f; exc_inject = e;
    if (f) exp_q.delete();
    if (v && inst_ready_o && !f) exp_q.push_back({e, d});
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (10) step(0, 0, 0, 0);
    checks++;
    if (inst_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: ready=%b expected 0", inst_ready_o);
    end
    checks++;
    if (ic_hold_o !== 1'b1 || ic_mds_o !== 1'b1 || ic_exception_o !== 1'b0 || ic_data_o !== NOP || fifo_count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: hold=%b mds=%b exc=%b data=%h count=%0d expected 1 1 0 %h 0",
               ic_hold_o, ic_mds_o, ic_exception_o, ic_data_o, fifo_count_o, NOP);
    end
    rst = 1;
    #1;
    checks++;
    if (inst_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: ready=%b expected 1", inst_ready_o);
    end
    mon_en = 1;
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1 || ic_data_o !== NOP || fifo_count_o !== 4'd0 || inst_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: hold=%b data=%h count=%0d ready=%b expected 1 %h 0 1",
               ic_hold_o, ic_data_o, fifo_count_o, inst_ready_o, NOP);
    end
  endtask

  task automatic test_single();
    step(1, 32'h8E00C002, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1 || fifo_count_o !== 4'd1) begin
      errors++; $display("FAIL single_wait: hold=%b count=%0d expected 1 1", ic_hold_o, fifo_count_o);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b0 || ic_mds_o !== 1'b0 || ic_data_o !== 32'h8E00C002 || fifo_count_o !== 4'd0) begin
      errors++;
      $display("FAIL single_deliver: hold=%b mds=%b data=%h count=%0d expected 0 0 8e00c002 0",
               ic_hold_o, ic_mds_o, ic_data_o, fifo_count_o);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1 || ic_data_o !== 32'h8E00C002) begin
      errors++; $display("FAIL single_hold_data: hold=%b data=%h expected 1 8e00c002", ic_hold_o, ic_data_o);
    end
  endtask

  task automatic test_stall();
    repeat (5) begin
      step(0, 0, 1, 0);
      checks++;
      if (ic_hold_o !== 1'b1) begin
        errors++; $display("FAIL stall_hold: hold=%b expected 1", ic_hold_o);
      end
    end
    step(1, 32'h82102005, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1 || fifo_count_o !== 4'd1) begin
      errors++; $display("FAIL stall_after_push: hold=%b count=%0d expected 1 1", ic_hold_o, fifo_count_o);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b0 || ic_data_o !== 32'h82102005) begin
      errors++; $display("FAIL stall_deliver: hold=%b data=%h expected 0 82102005", ic_hold_o, ic_data_o);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1) begin
      errors++; $display("FAIL stall_back_idle: hold=%b expected 1", ic_hold_o);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 32'hDEADBEEF, 0, 0);
    step(0, 0, 1, 0);
    @(negedge clk);
    rst = 0; fetch_req = 0; inst_valid = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (ic_hold_o !== 1'b1 || fifo_count_o !== 4'd0 || ic_data_o !== NOP) begin
        errors++;
        $display("FAIL reset_mid: hold=%b count=%0d data=%h expected 1 0 %h", ic_hold_o, fifo_count_o, ic_data_o, NOP);
      end
    end
  endtask

  task automatic test_stream();
    int k = 0, n = 0, first = -1, last = 0;
    for (int c = 0; c < 200 && n < 12; c++) begin
      step(k < 12, 32'hC0DE0000 + 32'(k), c >= 9, 0);
      if (k < 12 && inst_valid && inst_ready_o) k++;
      if (c == 8) begin
        checks++;
        if (inst_ready_o !== 1'b0 || fifo_count_o !== 4'd8) begin
          errors++; $display("FAIL stream_full: ready=%b count=%0d expected 0 8", inst_ready_o, fifo_count_o);
        end
      end
      if (ic_hold_o === 1'b0) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++;
    if (n != 12 || last - first != 22) begin
      errors++; $display("FAIL stream_rate: deliveries=%0d span=%0d expected 12 22", n, last - first);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b1 || fifo_count_o !== 4'd0) begin
      errors++; $display("FAIL stream_end: hold=%b count=%0d expected 1 0", ic_hold_o, fifo_count_o);
    end
  endtask

  task automatic test_flush();
    step(1, 32'hA5A50001, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'hA5A50002, 0, 0);
    step(1, 32'hA5A50003, 0, 0);
    step(1, 32'hA5A50004, 0, 0);
    step(1, 32'hA5A50005, 0, 1);
    step(0, 0, 0, 0);
    checks++;
    if (fifo_count_o !== 4'd0 || ic_hold_o !== 1'b1 || ic_data_o !== NOP || inst_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: count=%0d hold=%b data=%h ready=%b expected 0 1 %h 1",
               fifo_count_o, ic_hold_o, ic_data_o, inst_ready_o, NOP);
    end
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (ic_hold_o !== 1'b1) begin
        errors++; $display("FAIL flush_stall: hold=%b expected 1", ic_hold_o);
      end
    end
    step(1, 32'hA5A50006, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ic_hold_o !== 1'b0 || ic_data_o !== 32'hA5A50006) begin
      errors++; $display("FAIL flush_new_push: hold=%b data=%h expected 0 a5a50006", ic_hold_o, ic_data_o);
    end
    step(0, 0, 0, 0);
  endtask

`ifdef GUVM_ICRESP_EXC_INJECT_EN
  task automatic test_exc();
    step(1, 32'h91D02000, 0, 0, 1'b1);
    step(1, 32'h91D02004, 0, 0, 1'b0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ic_exception_o !== 1'b0) begin
      errors++; $display("FAIL exc_wait: exc=%b expected 0", ic_exception_o);
    end
    step(0, 0, 1, 0);
    checks++;
    if (ic_exception_o !== 1'b1 || ic_data_o !== 32'h91D02000) begin
      errors++; $display("FAIL exc_deliver: exc=%b data=%h expected 1 91d02000", ic_exception_o, ic_data_o);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ic_exception_o !== 1'b0 || ic_hold_o !== 1'b0 || ic_data_o !== 32'h91D02004) begin
      errors++;
      $display("FAIL exc_clean: exc=%b hold=%b data=%h expected 0 0 91d02004", ic_exception_o, ic_hold_o, ic_data_o);
    end
    step(0, 0, 0, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_reset_mid();
    test_stream();
    test_flush();
`ifdef GUVM_ICRESP_EXC_INJECT_EN
    test_exc();
`endif
    step(0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
